// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one WIDTH-bit up counter among NREQ requesters, one timed interval at a time.
// Define COUNTER_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module counter_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] target,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [NREQ-1:0]       done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;

  logic [WIDTH-1:0] tgt_arr [NREQ];
  logic             any_req;
  logic             owner_req;
  logic             at_tc;
  logic [IW-1:0]    win;

  for (genvar gi = 0; gi < NREQ; gi++) begin : gen_unpack
    assign tgt_arr[gi] = target[gi*WIDTH +: WIDTH];
  end

  assign any_req   = |req;
  assign owner_req = |(req & grant_q);
  assign at_tc     = (count_q == tgt_q);

`ifdef COUNTER_ARB_RR_EN
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] rr_idx;
  logic          rr_found;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    win      = rr_ptr_q;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = IW'((int'(rr_ptr_q) + k) % NREQ);
      if (!rr_found && req[rr_idx]) begin
        win      = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_IDLE && any_req) begin
      rr_ptr_d = win;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= IW'(NREQ - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[IW'(k)]) begin
        win = IW'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!owner_req) begin
          state_d = S_IDLE;
        end else if (at_tc) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Abandon takes priority over terminal count, so a dropped request never sees done.
  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    count_d = count_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = NREQ'(1) << win;
          busy_d  = 1'b1;
          count_d = '0;
          tgt_d   = tgt_arr[win];
        end
      end
      S_RUN: begin
        if (!owner_req) begin
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
        end else if (at_tc) begin
          done_d  = grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      S_DONE: begin
        count_d = '0;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: directed scenarios plus randomized traffic, checked every cycle against an interval-level model.
module tb_counter_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] target = '0;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [NREQ-1:0]       done;

  int n_pass  = 0;
  int n_total = 0;

  counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .target (target),
    .grant  (grant),
    .busy   (busy),
    .count  (count),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: an owner holds the counter for target+1 edges (elapsed = count),
  // then one done edge, then one idle edge before the next grant.
  int              m_owner = -1;
  int              m_last  = NREQ - 1;
  int              m_tgt   = 0;
  int              m_count = 0;
  bit              m_busy  = 1'b0;
  bit [NREQ-1:0]   m_grant = '0;
  bit [NREQ-1:0]   m_done  = '0;

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef COUNTER_ARB_RR_EN
    for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner = -1; m_last = NREQ - 1; m_tgt = 0; m_count = 0;
      m_busy = 1'b0; m_grant = '0; m_done = '0;
    end else if (m_done != 0) begin
      m_done  = '0;
      m_count = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1; m_grant = '0; m_busy = 1'b0; m_count = 0;
      end else if (m_count == m_tgt) begin
        m_done = m_grant; m_grant = '0; m_busy = 1'b0; m_owner = -1;
      end else begin
        m_count = m_count + 1;
      end
    end else if (req != 0) begin
      m_owner = pick(req, m_last);
      m_last  = m_owner;
      m_tgt   = int'(target[m_owner*WIDTH +: WIDTH]);
      m_grant = '0;
      m_grant[m_owner] = 1'b1;
      m_busy  = 1'b1;
      m_count = 0;
    end
  end

  always @(negedge clk) begin
    check("cyc_grant", int'(grant), int'(m_grant));
    check("cyc_done",  int'(done),  int'(m_done));
    check("cyc_busy",  int'(busy),  int'(m_busy));
    check("cyc_count", int'(count), m_count);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  logic [NREQ-1:0] got [5];
  logic [NREQ-1:0] exp_seq [5];
  logic [NREQ-1:0] prev_grant;
  int              n_got;
  int              tsel;

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    tick(2);
    check("rst_grant", int'(grant), 0);
    check("rst_busy",  int'(busy),  0);
    check("rst_count", int'(count), 0);
    check("rst_done",  int'(done),  0);
    #2 reset = 1'b1;
    tick();

    // single request, target 3
    target = '0; target[3:0] = 4'd3; req = 4'b0001;
    tick();
    check("single_grant", int'(grant), 1);
    check("single_busy",  int'(busy),  1);
    check("single_c0",    int'(count), 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("single_count", int'(count), k);
    end
    tick();
    check("single_done",   int'(done),  1);
    check("single_gnt0",   int'(grant), 0);
    check("single_cnthld", int'(count), 3);
    req = '0;
    tick();
    check("single_done0", int'(done),  0);
    check("single_cnt0",  int'(count), 0);

    // contention, all targets 1
    do_reset();
    target = {NREQ{4'd1}}; req = 4'hF;
`ifdef COUNTER_ARB_RR_EN
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
`else
    for (int i = 0; i < 5; i++) exp_seq[i] = 4'b0001;
`endif
    for (int i = 0; i < 5; i++) got[i] = '0;
    n_got = 0; prev_grant = '0;
    for (int c = 0; c < 40 && n_got < 5; c++) begin
      tick();
      if (grant != 0 && prev_grant == 0) begin
        got[n_got] = grant;
        n_got++;
      end
      prev_grant = grant;
    end
    check("cont_ngrants", n_got, 5);
    for (int i = 0; i < 5; i++) check("cont_grant", int'(got[i]), int'(exp_seq[i]));
    req = '0;
    tick(3);

    // abandon at count 4, pending requester 2 takes over
    do_reset();
    target = '0; target[7:4] = 4'd9; target[11:8] = 4'd2; req = 4'b0010;
    for (int c = 0; c < 20 && count != 4; c++) tick();
    check("ab_reach4", int'(count), 4);
    req = 4'b0100;
    tick();
    check("ab_grant0", int'(grant), 0);
    check("ab_count0", int'(count), 0);
    check("ab_busy0",  int'(busy),  0);
    check("ab_nodone", int'(done),  0);
    tick();
    check("ab_next", int'(grant), 4);
    req = '0;
    tick(3);

    // target 0
    do_reset();
    target = '0; req = 4'b0001;
    tick();
    check("t0_grant", int'(grant), 1);
    tick();
    check("t0_done",  int'(done),  1);
    check("t0_count", int'(count), 0);
    req = '0;
    tick(2);

    // target all-ones, target change mid-run ignored
    target[15:12] = 4'd15; req = 4'b1000;
    tick();
    check("tmax_grant", int'(grant), 8);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 3) target[15:12] = 4'd9;
    end
    check("tmax_count15", int'(count), 15);
    check("tmax_nodone",  int'(done),  0);
    tick();
    check("tmax_done",    int'(done),  8);
    check("tmax_cnthold", int'(count), 15);
    req = '0;
    tick(2);

    // asynchronous reset mid-run
    do_reset();
    target = '0; target[3:0] = 4'd9; req = 4'b0001;
    for (int c = 0; c < 20 && count != 5; c++) tick();
    check("rr_reach5", int'(count), 5);
    #2 reset = 1'b0;
    #1;
    check("arst_grant", int'(grant), 0);
    check("arst_busy",  int'(busy),  0);
    check("arst_count", int'(count), 0);
    check("arst_done",  int'(done),  0);
    req = 4'b1000;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("arst_regrant", int'(grant), 8);
    req = '0;
    tick(3);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 19) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 7) == 0) begin
        tsel = int'($urandom_range(0, NREQ - 1));
        target[tsel*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
      end
      @(negedge clk);
    end
    req = '0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
